// File: rtl/stack_pkg.sv
// stack_pkg: shared widths, flag bit positions, reset defaults and FSM states for the stack sequencer.
package stack_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;
  localparam int PC_W_DEF = 32;
  localparam int FLAG_W = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam logic [ADDR_W_DEF-1:0] SP_RESET_DEF = 12'hFFF;
  localparam logic [PC_W_DEF-1:0] INT_VEC_DEF = 32'h0000_0020;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_HI,
    S_WR_LO,
    S_WR_FLG,
    S_RD_FLG,
    S_RD_LO,
    S_RD_HI
  } state_e;
endpackage

// File: rtl/stack_sequencer_sp.sv
// stack_pointer: stack pointer register with increment/decrement strobes, wrapping modulo 2^ADDR_W.
module stack_pointer #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus1
);
  logic [ADDR_W-1:0] sp_q, sp_d;
  assign sp = sp_q;
  assign sp_plus1 = sp_q + ADDR_W'(1);
  assign sp_d = inc ? sp_plus1 : dec ? sp_q - ADDR_W'(1) : sp_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sp_q <= SP_RESET;
    else sp_q <= sp_d;
  end
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: memory-stage stack controller sequencing PUSH/POP, CALL/RET, interrupt entry and RTI.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter logic [ADDR_W-1:0] SP_RESET = SP_RESET_DEF,
  parameter logic [PC_W-1:0] INT_VEC = INT_VEC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              call,
  input  logic              ret,
  input  logic              rti,
  input  logic              intr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [PC_W-1:0]   call_target,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_value,
  output logic              int_ack,
  output logic              stall,
  output logic [ADDR_W-1:0] sp
);
  state_e state_q, state_d;
  logic int_pend_q, int_pend_d, intr_q, is_int_q, is_int_d, accept_int, inc, dec;
  logic [PC_W-1:0] ret_q, ret_d, tgt_q, tgt_d;
  logic [FLAG_W-1:0] flg_q, flg_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] sp_plus1;
  stack_pointer #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET)) u_sp (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .sp(sp), .sp_plus1(sp_plus1)
  );
  always_comb begin
    state_d = state_q;
    is_int_d = is_int_q;
    ret_d = ret_q;
    tgt_d = tgt_q;
    flg_d = flg_q;
    lo_d = lo_q;
    accept_int = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    pop_data = '0;
    pop_valid = 1'b0;
    pc_load = 1'b0;
    pc_value = '0;
    flags_load = 1'b0;
    flags_value = '0;
    int_ack = 1'b0;
    stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (int_pend_q) begin
          stall = 1'b1;
          accept_int = 1'b1;
          is_int_d = 1'b1;
          ret_d = ret_pc;
          flg_d = flags_in;
          state_d = S_WR_HI;
        end else if (rti) begin
          stall = 1'b1;
          state_d = S_RD_FLG;
        end else if (ret) begin
          stall = 1'b1;
          state_d = S_RD_LO;
        end else if (call) begin
          stall = 1'b1;
          is_int_d = 1'b0;
          ret_d = ret_pc;
          tgt_d = call_target;
          state_d = S_WR_HI;
        end else if (pop) begin
          mem_re = 1'b1;
          mem_addr = sp_plus1;
          pop_data = mem_rdata;
          pop_valid = 1'b1;
          inc = 1'b1;
        end else if (push) begin
          mem_we = 1'b1;
          mem_addr = sp;
          mem_wdata = push_data;
          dec = 1'b1;
        end
      end
      S_WR_HI: begin
        mem_we = 1'b1;
        mem_addr = sp;
        mem_wdata = ret_q[PC_W-1:DATA_W];
        dec = 1'b1;
        stall = 1'b1;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        mem_we = 1'b1;
        mem_addr = sp;
        mem_wdata = ret_q[DATA_W-1:0];
        dec = 1'b1;
        stall = is_int_q;
        pc_load = ~is_int_q;
        pc_value = is_int_q ? '0 : tgt_q;
        state_d = is_int_q ? S_WR_FLG : S_IDLE;
      end
      S_WR_FLG: begin
        mem_we = 1'b1;
        mem_addr = sp;
        mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, flg_q};
        dec = 1'b1;
        pc_load = 1'b1;
        pc_value = INT_VEC;
        int_ack = 1'b1;
        state_d = S_IDLE;
      end
      S_RD_FLG: begin
        mem_re = 1'b1;
        mem_addr = sp_plus1;
        inc = 1'b1;
        flags_load = 1'b1;
        flags_value = mem_rdata[FLAG_C:FLAG_Z];
        stall = 1'b1;
        state_d = S_RD_LO;
      end
      S_RD_LO: begin
        mem_re = 1'b1;
        mem_addr = sp_plus1;
        inc = 1'b1;
        lo_d = mem_rdata;
        stall = 1'b1;
        state_d = S_RD_HI;
      end
      S_RD_HI: begin
        mem_re = 1'b1;
        mem_addr = sp_plus1;
        inc = 1'b1;
        pc_load = 1'b1;
        pc_value = {mem_rdata, lo_q};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a fresh request arriving in the accept cycle stays pending for the next IDLE
    int_pend_d = (int_pend_q & ~accept_int) | (intr & ~intr_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      int_pend_q <= 1'b0;
      intr_q <= 1'b0;
      is_int_q <= 1'b0;
      ret_q <= '0;
      tgt_q <= '0;
      flg_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      int_pend_q <= int_pend_d;
      intr_q <= intr;
      is_int_q <= is_int_d;
      ret_q <= ret_d;
      tgt_q <= tgt_d;
      flg_q <= flg_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: scoreboard bench; expected memory writes, PC loads, pops and flag restores are queued at stimulus time.
module tb_stack_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic push = 0, pop = 0, call = 0, ret = 0, rti = 0, intr = 0;
  logic [15:0] push_data = '0;
  logic [31:0] call_target = '0, ret_pc = '0;
  logic [2:0] flags_in = '0;
  logic [15:0] mem_rdata, mem_wdata, pop_data;
  logic [11:0] mem_addr, sp;
  logic mem_we, mem_re, pop_valid, pc_load, flags_load, int_ack, stall;
  logic [31:0] pc_value;
  logic [2:0] flags_value;
  logic [15:0] mem [4096];
  logic [31:0] exp_wr[$], exp_pc[$], exp_pop[$], exp_flg[$];
  int total = 0, bad = 0, ack_left = 0;

  stack_sequencer dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .call(call), .ret(ret), .rti(rti),
    .intr(intr), .push_data(push_data), .call_target(call_target), .ret_pc(ret_pc),
    .flags_in(flags_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .pop_data(pop_data), .pop_valid(pop_valid),
    .pc_load(pc_load), .pc_value(pc_value), .flags_load(flags_load), .flags_value(flags_value),
    .int_ack(int_ack), .stall(stall), .sp(sp)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    exp_wr.push_back({4'h0, a, d});
  endtask

  always @(negedge clk) if (!reset) begin
    if (mem_we) begin
      chk("wr_extra", 32'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) chk("wr", {4'h0, mem_addr, mem_wdata}, exp_wr.pop_front());
    end
    if (pc_load) begin
      chk("pc_extra", 32'(exp_pc.size() > 0), 1);
      if (exp_pc.size() > 0) chk("pc", pc_value, exp_pc.pop_front());
    end
    if (pop_valid) begin
      chk("pop_extra", 32'(exp_pop.size() > 0), 1);
      if (exp_pop.size() > 0) chk("pop", 32'(pop_data), exp_pop.pop_front());
    end
    if (flags_load) begin
      chk("flg_extra", 32'(exp_flg.size() > 0), 1);
      if (exp_flg.size() > 0) chk("flg", 32'(flags_value), exp_flg.pop_front());
    end
    if (int_ack) begin
      chk("ack_extra", 32'(ack_left > 0), 1);
      ack_left--;
      chk("ack_pcload", 32'(pc_load), 1);
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    #12;
    chk("rst_sp", 32'(sp), 32'hFFF);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_pc", pc_value, 0);
    chk("rst_we", 32'(mem_we), 0);
    reset = 1'b0;
    tick();
    push = 1; push_data = 16'hBEEF; wr(12'hFFF, 16'hBEEF);
    @(negedge clk); chk("push_stall", 32'(stall), 0);
    tick(); push = 0;
    @(negedge clk); chk("push_sp", 32'(sp), 32'hFFE);
    tick();
    pop = 1; exp_pop.push_back(32'hBEEF);
    @(negedge clk); chk("pop_addr", 32'(mem_addr), 32'hFFF); chk("pop_stall", 32'(stall), 0);
    tick(); pop = 0;
    @(negedge clk); chk("pop_sp", 32'(sp), 32'hFFF);
    tick();
    ret_pc = 32'h0001_0005; call_target = 32'h0000_0100; call = 1;
    wr(12'hFFF, 16'h0001); wr(12'hFFE, 16'h0005); exp_pc.push_back(32'h100);
    @(negedge clk); chk("call_stall0", 32'(stall), 1);
    tick(); call = 0;
    @(negedge clk); chk("call_stall1", 32'(stall), 1);
    tick();
    @(negedge clk); chk("call_stall2", 32'(stall), 0); chk("call_pcload2", 32'(pc_load), 1);
    tick();
    @(negedge clk); chk("call_sp", 32'(sp), 32'hFFD);
    tick();
    ret = 1; exp_pc.push_back(32'h0001_0005);
    @(negedge clk); chk("ret_stall0", 32'(stall), 1);
    tick(); ret = 0;
    @(negedge clk); chk("ret_addr1", 32'(mem_addr), 32'hFFE);
    tick();
    @(negedge clk); chk("ret_addr2", 32'(mem_addr), 32'hFFF); chk("ret_pcload", 32'(pc_load), 1);
    tick();
    @(negedge clk); chk("ret_sp", 32'(sp), 32'hFFF);
    tick();
    ret_pc = 32'h0001_0005; call_target = 32'h0000_0100; flags_in = 3'b101; call = 1;
    wr(12'hFFF, 16'h0001); wr(12'hFFE, 16'h0005); exp_pc.push_back(32'h100);
    wr(12'hFFD, 16'h0000); wr(12'hFFC, 16'h0101); wr(12'hFFB, 16'h0005);
    exp_pc.push_back(32'h20); ack_left++;
    tick(); call = 0; intr = 1; ret_pc = 32'h0000_0101;
    tick(); intr = 0;
    tick();
    @(negedge clk); chk("int_stall0", 32'(stall), 1);
    tick(); tick();
    @(negedge clk); chk("int_stall2", 32'(stall), 1);
    tick();
    @(negedge clk); chk("int_ack", 32'(int_ack), 1); chk("int_stall3", 32'(stall), 0);
    tick();
    @(negedge clk); chk("int_sp", 32'(sp), 32'hFFA);
    tick();
    rti = 1; exp_flg.push_back(32'h5); exp_pc.push_back(32'h0000_0101);
    tick(); rti = 0;
    tick(); tick();
    @(negedge clk); chk("rti_pcload", 32'(pc_load), 1);
    tick();
    @(negedge clk); chk("rti_sp", 32'(sp), 32'hFFD);
    tick();
    ret = 1; exp_pc.push_back(32'h0001_0005);
    tick(); ret = 0;
    tick(); tick();
    @(negedge clk); chk("ret2_sp", 32'(sp), 32'hFFF);
    tick();
    for (int i = 0; i < 4095; i++) begin
      push = 1; push_data = 16'(i); wr(12'(4095 - i), 16'(i));
      tick();
    end
    push = 0;
    @(negedge clk); chk("wrap_sp0", 32'(sp), 0);
    tick();
    push = 1; push_data = 16'h1234; wr(12'h000, 16'h1234);
    tick(); push = 0;
    @(negedge clk); chk("wrap_sp", 32'(sp), 32'hFFF);
    tick();
    call = 1; push = 1; push_data = 16'hDEAD; ret_pc = 32'h42; call_target = 32'h200;
    wr(12'hFFF, 16'h0000); wr(12'hFFE, 16'h0042); exp_pc.push_back(32'h200);
    @(negedge clk); chk("cp_we0", 32'(mem_we), 0);
    tick(); call = 0; push = 0;
    tick(); tick();
    @(negedge clk); chk("cp_sp", 32'(sp), 32'hFFD);
    tick();
    ret_pc = 32'h201; flags_in = 3'b011; intr = 1;
    wr(12'hFFD, 16'h0000); wr(12'hFFC, 16'h0201); wr(12'hFFB, 16'h0003);
    exp_pc.push_back(32'h20); ack_left++;
    tick(); intr = 0;
    tick(); tick(); tick(); tick();
    @(negedge clk); chk("int2_sp", 32'(sp), 32'hFFA);
    tick();
    rti = 1; exp_flg.push_back(32'h3);
    tick(); rti = 0; intr = 1;
    tick(); intr = 0; reset = 1;
    #1;
    chk("ar_re", 32'(mem_re), 0);
    chk("ar_we", 32'(mem_we), 0);
    chk("ar_addr", 32'(mem_addr), 0);
    chk("ar_pcload", 32'(pc_load), 0);
    chk("ar_pc", pc_value, 0);
    chk("ar_stall", 32'(stall), 0);
    chk("ar_sp", 32'(sp), 32'hFFF);
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_pcload", 32'(pc_load), 0);
      chk("post_we", 32'(mem_we), 0);
      tick();
    end
    chk("post_sp", 32'(sp), 32'hFFF);
    chk("wr_left", 32'(exp_wr.size()), 0);
    chk("pc_left", 32'(exp_pc.size()), 0);
    chk("pop_left", 32'(exp_pop.size()), 0);
    chk("flg_left", 32'(exp_flg.size()), 0);
    chk("ack_left", 32'(ack_left), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
